// File: rtl/clk_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : clk_freq_meter
//  Purpose  : Measures the period of an asynchronous clock (clkin) in cycles
//             of the reference clock (clksrc). Reports each new period,
//             tracks lock against a nominal period with tolerance, flags a
//             stopped clock, and counts out-of-tolerance periods.
//  Revision : 1.0 - initial release
// ============================================================================
//  Timing: clkin sampled high on clksrc edge N gives a period_valid pulse
//  registered on edge N+3. Sync stage 1 (N), sync stage 2 (N+1), edge-detect
//  register (N+2), measurement/output register (N+3). The pulse is therefore
//  high during the fourth clksrc cycle counted from the sampling edge.
// ============================================================================
module clk_freq_meter #(
    parameter int FREQ_INPUT    = 12_000_000,
    parameter int FREQ_EXPECTED = 1_000,
    parameter int TOL           = 2,
    parameter int LOCK_COUNT    = 4,
    parameter int EXP_PERIOD    = FREQ_INPUT / FREQ_EXPECTED,
    parameter int TIMEOUT_CYC   = 2 * EXP_PERIOD,
    parameter int CNT_WIDTH     = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                 rstn,
    input  logic                 clksrc,
    input  logic                 clkin,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 timeout,
    output logic [7:0]           err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_WIDTH-1:0] EXP_W     = CNT_WIDTH'(EXP_PERIOD);
    localparam logic [CNT_WIDTH-1:0] TOL_W     = CNT_WIDTH'(TOL);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_W = CNT_WIDTH'(TIMEOUT_CYC);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [GOOD_W-1:0]    GOOD_MAX  = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0]    GOOD_ONE  = GOOD_W'(1);
    localparam logic [7:0]           ERR_MAX   = 8'hFF;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Synchronizer and edge-detect pipeline
    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic edge_q;

    // Measurement state
    state_t                state_q,  state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic                  valid_q,  valid_d;
    logic                  locked_q, locked_d;
    logic                  timeout_q, timeout_d;
    logic [GOOD_W-1:0]     good_q,   good_d;
    logic [7:0]            err_q,    err_d;

    logic [CNT_WIDTH-1:0]  diff_w;
    logic                  in_tol_w;
    logic [GOOD_W-1:0]     good_inc_w;

    // Absolute deviation from nominal, taking the non-wrapping ordering.
    assign diff_w     = (cnt_q >= EXP_W) ? (cnt_q - EXP_W) : (EXP_W - cnt_q);
    assign in_tol_w   = (diff_w <= TOL_W);
    assign good_inc_w = (good_q == GOOD_MAX) ? good_q : (good_q + GOOD_ONE);

    // Bring clkin into the clksrc domain and register a one-cycle rising-edge strobe.
    always_ff @(posedge clksrc or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= clkin;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            edge_q  <= sync2_q & ~hist_q;
        end
    end

    // Next-state logic: period capture, lock tracking, error counting, timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        good_d    = good_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                // First edge only opens the measurement window.
                if (edge_q) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                // An edge wins over a coincident timeout.
                if (edge_q) begin
                    period_d  = cnt_q;
                    valid_d   = 1'b1;
                    cnt_d     = CNT_ONE;
                    timeout_d = 1'b0;
                    if (in_tol_w) begin
                        good_d   = good_inc_w;
                        locked_d = (good_inc_w == GOOD_MAX);
                    end else begin
                        good_d   = '0;
                        locked_d = 1'b0;
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 8'd1;
                        end
                    end
                end else if (cnt_q == TIMEOUT_W) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    good_d    = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clksrc or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            good_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            good_q    <= good_d;
            err_q     <= err_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
    assign err_cnt      = err_q;

endmodule
`default_nettype wire
